// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port, with a local occupancy credit count.
// Define FIFO_ARB_MAXBURST_EN to release ownership after MAX_BURST transfers.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_pop,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OWN_W = $clog2(NUM_REQ);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_param_check
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
  end

  typedef enum logic {IDLE, OWN} state_e;

  state_e                  state_q;
  logic [OWN_W-1:0]        owner_q;
  logic [OWN_W-1:0]        rr_q;
  logic [OCC_W-1:0]        occ_q;
  logic [OCC_W-1:0]        occ_d;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic                    busy_q;

  logic [OWN_W-1:0]        winner_d;
  logic [OWN_W-1:0]        cand_d;
  logic                    found_d;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_req;
  logic                    sel_last;
  logic                    accept;
  logic                    pop_ok;
  logic                    burst_done;

`ifdef FIFO_ARB_MAXBURST_EN
  localparam int BST_W = $clog2(MAX_BURST) + 1;
  logic [BST_W-1:0] burst_q;
  assign burst_done = (burst_q == BST_W'(MAX_BURST - 1));
`else
  assign burst_done = 1'b0;
`endif

  always_comb begin
    sel_data = '0;
    sel_req  = 1'b0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWN_W'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_req  = req[OWN_W'(i)];
        sel_last = req_last[OWN_W'(i)];
      end
    end
  end

  // Search starts just after the last owner so every requester gets a turn.
  always_comb begin
    winner_d = rr_q;
    cand_d   = '0;
    found_d  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_d = OWN_W'((32'(rr_q) + k) % NUM_REQ);
      if (!found_d && req[cand_d]) begin
        winner_d = cand_d;
        found_d  = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == OWN) begin
      gnt[owner_q] = sel_req && !fifo_full && (occ_q < DEPTH_C);
    end
  end

  assign accept = |gnt;

  always_comb begin
    pop_ok = fifo_pop && (occ_q != '0);
    occ_d  = occ_q;
    if (accept && !pop_ok) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && pop_ok) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= OWN_W'(NUM_REQ - 1);
      wr_q    <= 1'b0;
      din_q   <= '0;
      occ_q   <= '0;
      busy_q  <= 1'b0;
`ifdef FIFO_ARB_MAXBURST_EN
      burst_q <= '0;
`endif
    end else begin
      occ_q <= occ_d;
      wr_q  <= accept;
      if (accept) begin
        din_q <= sel_data;
      end
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= OWN;
            owner_q <= winner_d;
            busy_q  <= 1'b1;
`ifdef FIFO_ARB_MAXBURST_EN
            burst_q <= '0;
`endif
          end
        end
        OWN: begin
          // A dropped req aborts; backpressure with req high keeps ownership.
          if (!sel_req || (accept && (sel_last || burst_done))) begin
            state_q <= IDLE;
            rr_q    <= owner_q;
            busy_q  <= 1'b0;
          end
`ifdef FIFO_ARB_MAXBURST_EN
          if (accept) begin
            burst_q <= burst_q + BST_W'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wr   = wr_q;
  assign fifo_din  = din_q;
  assign occupancy = occ_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester word queues drive the DUT, a transaction-level
// model predicts every output each cycle, and literal checks pin the model on the key scenarios.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int D  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic           fifo_full = 1'b0;
  logic           fifo_pop = 1'b0;
  logic           fifo_wr;
  logic [W-1:0]   fifo_din;
  logic [3:0]     occupancy;
  logic [1:0]     owner;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(W), .FIFO_DEPTH(D), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_last(req_last), .req_data(req_data),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_pop(fifo_pop), .fifo_wr(fifo_wr),
    .fifo_din(fifo_din), .occupancy(occupancy), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Producers: each requester presents the head of its queue; a granted word is consumed.
  logic [W-1:0] wd [N][16];
  bit           wl [N][16];
  int           head [N];
  int           cnt  [N];
  logic [N-1:0] gs = '0;

  initial for (int i = 0; i < N; i++) begin head[i] = 0; cnt[i] = 0; end

  task automatic push(input int i, input logic [W-1:0] d, input bit l);
    wd[i][(head[i] + cnt[i]) % 16] = d;
    wl[i][(head[i] + cnt[i]) % 16] = l;
    cnt[i]++;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin head[i] = 0; cnt[i] = 0; end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      req[i]             = cnt[i] > 0;
      req_last[i]        = (cnt[i] > 0) ? wl[i][head[i]] : 1'b0;
      req_data[i*W +: W] = (cnt[i] > 0) ? wd[i][head[i]] : '0;
    end
    #3 gs = gnt & req;
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (gs[i] && cnt[i] > 0) begin
        head[i] = (head[i] + 1) % 16;
        cnt[i]--;
      end
    end
  end

  // Transaction-level model: who holds the port, where the rotation resumes, FIFO fill level.
  bit         m_own = 0;
  int         m_owner = 0;
  int         m_rr = N - 1;
  int         m_occ = 0;
  int         m_burst = 0;
  bit         m_wr = 0;
  logic [W-1:0] m_din = '0;
  bit         m_acc;
  int         m_nocc;
  logic [N-1:0] eg;

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      if (req[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return m_rr;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own = 0; m_owner = 0; m_rr = N - 1; m_occ = 0; m_burst = 0; m_wr = 0; m_din = '0;
    end else begin
      m_acc  = m_own && req[m_owner] && !fifo_full && (m_occ < D);
      m_nocc = m_occ + (m_acc ? 1 : 0) - ((fifo_pop && m_occ > 0) ? 1 : 0);
      m_wr   = m_acc;
      if (m_acc) m_din = req_data[m_owner*W +: W];
      if (!m_own) begin
        if (req != '0) begin m_owner = pick(); m_own = 1; m_burst = 0; end
      end else if (!req[m_owner]) begin
        m_own = 0; m_rr = m_owner;
      end else if (m_acc) begin
        m_burst++;
`ifdef FIFO_ARB_MAXBURST_EN
        if (req_last[m_owner] || m_burst == MB) begin m_own = 0; m_rr = m_owner; end
`else
        if (req_last[m_owner]) begin m_own = 0; m_rr = m_owner; end
`endif
      end
      m_occ = m_nocc;
    end
  end

  logic [63:0] logd [32];
  int          logc [32];
  int          logn = 0;

  always @(negedge clk) begin
    #2;
    eg = '0;
    if (m_own && req[m_owner] && !fifo_full && m_occ < D) eg[m_owner] = 1'b1;
    chk("gnt", gnt, eg);
    chk("fifo_wr", fifo_wr, m_wr);
    chk("fifo_din", fifo_din, m_din);
    chk("occupancy", occupancy, m_occ);
    chk("owner", owner, m_owner);
    chk("busy", busy, m_own);
    if (fifo_wr === 1'b1 && logn < 32) begin
      logd[logn] = fifo_din; logc[logn] = cyc; logn++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; fifo_full = 1'b0; fifo_pop = 1'b0;
    clear_queues();
    @(posedge clk); #1;
    reset = 1'b0;
    logn = 0;
  endtask

  task automatic wait_quiet(input int maxc, input string nm);
    bit done;
    done = 0;
    for (int k = 0; k < maxc && !done; k++) begin
      tick(1);
      if (cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0 && cnt[3] == 0 && busy === 1'b0 && fifo_wr === 1'b0)
        done = 1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL %s timeout after %0d cycles", nm, maxc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [63:0] exp2 [6];
  int c0;

  initial begin
    do_reset();
    chk("rst_occ", occupancy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_owner", owner, 0);

    // Single requester, three-word burst.
    c0 = cyc;
    push(1, 64'h11, 0); push(1, 64'h22, 0); push(1, 64'h33, 1);
    wait_quiet(20, "t1");
    chk("t1_nwr", logn, 3);
    chk("t1_d0", logd[0], 64'h11);
    chk("t1_d1", logd[1], 64'h22);
    chk("t1_d2", logd[2], 64'h33);
    chk("t1_lat0", logc[0] - c0, 2);
    chk("t1_lat2", logc[2] - c0, 4);
    chk("t1_occ", occupancy, 3);
    chk("t1_owner", owner, 1);
    fifo_pop = 1'b1;
    tick(4);
    fifo_pop = 1'b0;
    chk("t1_drain_occ", occupancy, 0);

    // Round-robin over requesters 0, 2, 3 with one-word bursts.
    do_reset();
    for (int r = 1; r <= 2; r++) begin
      push(0, 64'h00 + r, 1); push(2, 64'h20 + r, 1); push(3, 64'h30 + r, 1);
    end
    fifo_pop = 1'b1;
    wait_quiet(40, "t2");
    fifo_pop = 1'b0;
    exp2[0] = 64'h01; exp2[1] = 64'h21; exp2[2] = 64'h31;
    exp2[3] = 64'h02; exp2[4] = 64'h22; exp2[5] = 64'h32;
    chk("t2_nwr", logn, 6);
    for (int k = 0; k < 6; k++) chk("t2_order", logd[k], exp2[k]);

    // Credit limit: no pops, ten words offered.
    do_reset();
    for (int k = 0; k < 10; k++) push(0, 64'h100 + k, k == 9);
    tick(25);
    chk("t3_nwr", logn, 8);
    chk("t3_occ", occupancy, 8);
    chk("t3_gnt", gnt, 4'b0000);
    chk("t3_busy", busy, 1);
    fifo_pop = 1'b1;
    tick(1);
    fifo_pop = 1'b0;
    chk("t3_occ_pop", occupancy, 7);
    chk("t3_gnt_resume", gnt, 4'b0001);
    tick(1);
    chk("t3_wr9", fifo_wr, 1);
    chk("t3_din9", fifo_din, 64'h108);
    chk("t3_occ9", occupancy, 8);
    fifo_pop = 1'b1;
    wait_quiet(30, "t3");
    fifo_pop = 1'b0;
    chk("t3_last", logd[9], 64'h109);

    // Write and pop in the same cycle at occupancy 5.
    do_reset();
    for (int k = 0; k < 5; k++) push(0, 64'h200 + k, k == 4);
    wait_quiet(20, "t4a");
    chk("t4_occ5", occupancy, 5);
    push(0, 64'hAA, 1);
    tick(1);
    fifo_pop = 1'b1;
    chk("t4_gnt", gnt, 4'b0001);
    tick(1);
    fifo_pop = 1'b0;
    chk("t4_occ_same", occupancy, 5);
    chk("t4_din", fifo_din, 64'hAA);

    // Reset in the middle of a burst.
    do_reset();
    for (int k = 0; k < 8; k++) push(2, 64'h300 + k, k == 7);
    for (int k = 0; k < 20 && occupancy !== 4'd4; k++) tick(1);
    chk("t5_occ4", occupancy, 4);
    chk("t5_inflight", fifo_wr, 1);
    reset = 1'b1;
    clear_queues();
    #1;
    chk("t5_wr", fifo_wr, 0);
    chk("t5_occ", occupancy, 0);
    chk("t5_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Abort by dropping req, then fifo_full backpressure.
    do_reset();
    push(1, 64'hA1, 0); push(1, 64'hA2, 0); push(3, 64'hB1, 1);
    wait_quiet(20, "t6a");
    chk("t6_nwr", logn, 3);
    chk("t6_d0", logd[0], 64'hA1);
    chk("t6_d1", logd[1], 64'hA2);
    chk("t6_d2", logd[2], 64'hB1);
    chk("t6_gap", logc[2] - logc[1], 3);
    chk("t6_owner", owner, 3);
    push(0, 64'hC1, 0); push(0, 64'hC2, 1);
    fifo_full = 1'b1;
    tick(1);
    chk("t6_full_busy", busy, 1);
    chk("t6_full_owner", owner, 0);
    chk("t6_full_gnt", gnt, 4'b0000);
    tick(2);
    chk("t6_full_hold", busy, 1);
    fifo_full = 1'b0;
    c0 = cyc;
    #1;
    chk("t6_resume_gnt", gnt, 4'b0001);
    wait_quiet(20, "t6b");
    chk("t6_c1", logd[3], 64'hC1);
    chk("t6_c2", logd[4], 64'hC2);
    chk("t6_c1_cyc", logc[3] - c0, 1);

`ifdef FIFO_ARB_MAXBURST_EN
    // Six-word burst split 4+2 around another requester.
    do_reset();
    for (int k = 0; k < 6; k++) push(2, 64'hD0 + k, k == 5);
    push(3, 64'hE0, 1);
    fifo_pop = 1'b1;
    wait_quiet(40, "t7");
    fifo_pop = 1'b0;
    chk("t7_nwr", logn, 7);
    chk("t7_d3", logd[3], 64'hD3);
    chk("t7_mid", logd[4], 64'hE0);
    chk("t7_d4", logd[5], 64'hD4);
    chk("t7_d5", logd[6], 64'hD5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one 64-bit hierarchical FIFO between NUM_REQ producers.
- Grants whole bursts, delimited by req_last, to one requester at a time.
- Registers the winning word onto the FIFO write interface (data_in_valid/data_in).
- Keeps its own occupancy credit count from writes and pops, so no word is ever offered to a full FIFO.

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- DATA_WIDTH, 64: FIFO word width.
- FIFO_DEPTH, 8: FIFO capacity in words; sizes the credit counter.
- MAX_BURST, 4: maximum words per ownership; used only when FIFO_ARB_MAXBURST_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester word-valid.
- req_last  in  NUM_REQ  final word of a burst; qualified by req.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  combinational accept; a word transfers when req[i]&&gnt[i].
- fifo_full  in  1  FIFO full flag.
- fifo_pop  in  1  FIFO pop strobe (same signal driving pop_fifo).
- fifo_wr  out  1  registered; drives data_in_valid.
- fifo_din  out  DATA_WIDTH  registered; drives data_in.
- occupancy  out  $clog2(FIFO_DEPTH)+1  credit count.
- owner  out  $clog2(NUM_REQ)  current or last owner index.
- busy  out  1  high in OWN state.

Behaviour:
Reset (asynchronous, immediate):
- state=IDLE, gnt=0, fifo_wr=0, fifo_din=0, occupancy=0.
- rr_ptr=NUM_REQ-1, so requester 0 wins first.
- owner=0, busy=0.

IDLE:
- gnt all 0.
- If any req: winner = first i with req[i] searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
- Next edge: state=OWN, owner=winner, busy=1.
- Arbitration costs exactly one cycle; no transfer occurs in the IDLE cycle.

OWN:
- gnt[owner] = req[owner] && !fifo_full && (occupancy < FIFO_DEPTH). All other gnt bits 0.
- On transfer: next edge fifo_wr=1, fifo_din=req_data[owner]. Write latency is one cycle from accept.
- Non-transfer cycles: fifo_wr=0; fifo_din holds its last value.
- Transfer with req_last[owner]=1: next state IDLE, rr_ptr=owner.
- req[owner] low for one cycle: burst aborted; next state IDLE, rr_ptr=owner. No word is written that cycle.
- Backpressure (fifo_full or no credit) while req[owner] is high: ownership is held and gnt stays 0. This is not an abort.

Credits:
- occupancy +1 on an accept edge; -1 when fifo_pop && occupancy>0.
- Both in the same cycle: unchanged.
- fifo_pop with occupancy==0: ignored, counter does not underflow.
- occupancy never exceeds FIFO_DEPTH.

Other rules:
- req_last without req is ignored.
- Requests from non-owners are held off; they see gnt=0 until arbitrated.
- Reset mid-burst: the in-flight registered word is dropped (fifo_wr forced 0) and the counter is cleared. The FIFO must be reset in the same event.

Optional Feature:
FIFO_ARB_MAXBURST_EN:
- Defined: a burst counter counts transfers within an ownership. After the MAX_BURST-th transfer the owner is released (next state IDLE, rr_ptr=owner) even if req_last=0. The requester re-arbitrates for the remainder of its burst.
- Undefined: no counter exists; ownership lasts until req_last or a req drop; MAX_BURST is unused.

Test Plan:
- Single requester: after reset, req[1]=1 with 3 words 0x11,0x22,0x33 and req_last on the third -> IDLE→OWN takes 1 cycle; fifo_wr high 3 consecutive cycles with data in order; occupancy=3; back to IDLE, owner=1.
- Round-robin fairness: req[0], req[2] and req[3] all held, 1-word bursts with req_last=1 -> grant order 0,2,3,0,2,3; no gnt overlap.
- Credit limit: FIFO_DEPTH=8, no pops, requester 0 streams 10 words -> exactly 8 fifo_wr pulses; gnt low with occupancy=8. Then one fifo_pop -> occupancy=7, the 9th word is accepted next cycle.
- Simultaneous pop and write at occupancy=5 -> occupancy stays 5. fifo_pop at occupancy=0 -> stays 0.
- Abort and fifo_full: owner drops req mid-burst -> IDLE next cycle, nothing written, next requester wins. fifo_full=1 while owner requests -> gnt=0, ownership held, transfer resumes the cycle after fifo_full falls.
- Reset mid-burst with occupancy=4 -> next cycle fifo_wr=0, occupancy=0, state IDLE. With FIFO_ARB_MAXBURST_EN and MAX_BURST=4, a 6-word burst from requester 2 is split into 4+2 words, with another requester's burst allowed in between.
